// File: rtl/sfx_tone_player.sv
// sfx_tone_player: multi-channel sound-effect square-wave generator for the
// pinball speaker. One tone plays at a time; lower channel index wins.
// Optional build macro: SFX_SWEEP_EN adds a falling-pitch sweep, growing the
// half-period by SWEEP_STEP on every toggle (saturating).
module sfx_tone_player #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned DUR_W      = 12,
  parameter int unsigned SWEEP_STEP = 64,
  localparam int unsigned CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         trig,
  input  logic [N_CH*DIV_W-1:0]   half_period,
  input  logic [N_CH*DUR_W-1:0]   duration,
  output logic                    spk,
  output logic                    busy,
  output logic [CW-1:0]           active_ch
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  logic [0:0]       state;
  logic [N_CH-1:0]  trig_q;
  logic [N_CH-1:0]  rise;
  logic             armed;
  logic [DIV_W-1:0] hp_l;
  logic [DIV_W-1:0] hp_next;
  logic [DIV_W-1:0] tone_cnt;
  logic [DUR_W-1:0] dur_l;
  logic [DUR_W-1:0] tog_cnt;
  logic [DUR_W-1:0] tog_next;
  logic             req;
  logic [CW-1:0]    req_idx;
  logic [DIV_W-1:0] req_hp;
  logic [DUR_W-1:0] req_dur;
  logic             half_done;
  logic             note_done;
  logic             accept;

  // Priority pick of the lowest channel with a rising edge and nonzero settings.
  // armed is low for the first edge after reset so a trig held high across
  // the release only loads trig_q and never counts as a rising edge.
  always_comb begin
    rise    = trig & ~trig_q;
    req     = 1'b0;
    req_idx = '0;
    req_hp  = '0;
    req_dur = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!req && armed && rise[i] &&
          half_period[i*DIV_W +: DIV_W] != '0 &&
          duration[i*DUR_W +: DUR_W] != '0) begin
        req     = 1'b1;
        req_idx = CW'(i);
        req_hp  = half_period[i*DIV_W +: DIV_W];
        req_dur = duration[i*DUR_W +: DUR_W];
      end
    end
  end

  // Half-period / note-end detection and request acceptance.
  always_comb begin
    half_done = (state == PLAY) && (tone_cnt == hp_l - DIV_W'(1));
    tog_next  = tog_cnt + DUR_W'(1);
    note_done = half_done && (tog_next == dur_l);
    accept    = req && ((state == IDLE) || (req_idx <= active_ch) || note_done);
  end

`ifdef SFX_SWEEP_EN
  logic [DIV_W:0] hp_sum;

  // Sweep: lengthen the half-period after every toggle, saturating at all-ones.
  always_comb begin
    hp_sum  = {1'b0, hp_l} + (DIV_W+1)'(SWEEP_STEP);
    hp_next = hp_sum[DIV_W] ? '1 : hp_sum[DIV_W-1:0];
  end
`else
  // No sweep: half-period stays fixed for the whole note.
  always_comb begin
    hp_next = hp_l;
  end
`endif

  // Tone FSM: start/restart, half-period counting, toggling and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q    <= '0;
      armed     <= 1'b0;
      state     <= IDLE;
      spk       <= 1'b0;
      busy      <= 1'b0;
      active_ch <= '0;
      tone_cnt  <= '0;
      tog_cnt   <= '0;
      hp_l      <= '0;
      dur_l     <= '0;
    end else begin
      trig_q <= trig;
      armed  <= 1'b1;
      if (accept) begin
        hp_l      <= req_hp;
        dur_l     <= req_dur;
        tone_cnt  <= '0;
        tog_cnt   <= '0;
        active_ch <= req_idx;
        busy      <= 1'b1;
        spk       <= 1'b0;
        state     <= PLAY;
      end else if (state == PLAY) begin
        if (half_done) begin
          tone_cnt <= '0;
          tog_cnt  <= tog_next;
          hp_l     <= hp_next;
          if (note_done) begin
            spk   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            spk <= ~spk;
          end
        end else begin
          tone_cnt <= tone_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule
